// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction-memory request/grant/response bus between fetch and imem.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - fetch PC, imem credit/grant/response tracking, 2-entry instruction queue.
// Optional static backward-taken/JAL prediction on queue write: IF_BTFN_PREDICT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  if_fetch_if.master  imem,
  input  logic        ex_branch_flag,
  input  logic [31:0] ex_branch_address,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic [31:0] if_inst
);

  logic [31:0] fpc_q, fpc_d;
  logic [1:0]  outs_q, outs_d;
  logic [1:0]  disc_q, disc_d;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_npc_q  [2];
  logic [31:0] q_inst_q [2];
  logic [31:0] q_pc_d   [2];
  logic [31:0] q_npc_d  [2];
  logic [31:0] q_inst_d [2];
  logic [1:0]  q_cnt_q, q_cnt_d;
  logic [31:0] fl_pc_q [2];
  logic [31:0] fl_pc_d [2];
  logic [1:0]  fl_cnt_q, fl_cnt_d;

  logic        pop, grant, resp, drop, push, req;
  logic [1:0]  cnt_eff;
  logic [31:0] rsp_pc, rsp_npc;
  logic        pred_taken;

  // Credit uses the occupancy left after this cycle's decode pop so a
  // 1-cycle memory can sustain one instruction per cycle.
  assign pop     = (q_cnt_q != 2'd0) && id_ready;
  assign cnt_eff = q_cnt_q - {1'b0, pop};
  assign req     = rstn && !ex_branch_flag &&
                   (({1'b0, cnt_eff} + {1'b0, outs_q}) < 3'd2);
  assign grant   = req && imem.imem_gnt;
  assign resp    = imem.imem_rvalid;
  assign drop    = resp && (disc_q != 2'd0);
  assign push    = resp && (disc_q == 2'd0);
  assign rsp_pc  = fl_pc_q[0];

  assign imem.imem_req  = req;
  assign imem.imem_addr = fpc_q;

`ifdef IF_BTFN_PREDICT_EN
  logic [31:0] b_imm, j_imm;
  logic        is_btake, is_jal;
  assign b_imm    = {{20{imem.imem_rdata[31]}}, imem.imem_rdata[7], imem.imem_rdata[30:25],
                     imem.imem_rdata[11:8], 1'b0};
  assign j_imm    = {{12{imem.imem_rdata[31]}}, imem.imem_rdata[19:12], imem.imem_rdata[20],
                     imem.imem_rdata[30:21], 1'b0};
  assign is_btake = (imem.imem_rdata[6:0] == 7'b1100011) && imem.imem_rdata[31];
  assign is_jal   = (imem.imem_rdata[6:0] == 7'b1101111);
  assign pred_taken = is_btake || is_jal;
  assign rsp_npc  = is_jal ? rsp_pc + j_imm : (is_btake ? rsp_pc + b_imm : rsp_pc + 32'd4);
`else
  assign pred_taken = 1'b0;
  assign rsp_npc    = rsp_pc + 32'd4;
`endif

  always_comb begin
    outs_d   = outs_q + {1'b0, grant} - {1'b0, resp};
    fpc_d    = grant ? fpc_q + 32'd4 : fpc_q;
    disc_d   = drop ? disc_q - 2'd1 : disc_q;
    fl_pc_d  = fl_pc_q;
    fl_cnt_d = fl_cnt_q;
    q_pc_d   = q_pc_q;
    q_npc_d  = q_npc_q;
    q_inst_d = q_inst_q;
    q_cnt_d  = q_cnt_q;

    if (push) begin
      fl_pc_d[0] = fl_pc_q[1];
      fl_cnt_d   = fl_cnt_q - 2'd1;
    end
    if (grant) begin
      if (fl_cnt_d == 2'd0) fl_pc_d[0] = fpc_q;
      else                  fl_pc_d[1] = fpc_q;
      fl_cnt_d = fl_cnt_d + 2'd1;
    end

    if (pop) begin
      q_pc_d[0]   = q_pc_q[1];
      q_npc_d[0]  = q_npc_q[1];
      q_inst_d[0] = q_inst_q[1];
      q_cnt_d     = q_cnt_q - 2'd1;
    end
    if (push) begin
      if (q_cnt_d == 2'd0) begin
        q_pc_d[0]   = rsp_pc;
        q_npc_d[0]  = rsp_npc;
        q_inst_d[0] = imem.imem_rdata;
      end else begin
        q_pc_d[1]   = rsp_pc;
        q_npc_d[1]  = rsp_npc;
        q_inst_d[1] = imem.imem_rdata;
      end
      q_cnt_d = q_cnt_d + 2'd1;
    end

    // Predicted-taken write: everything still in flight is wrong-path.
    if (push && pred_taken) begin
      fpc_d    = rsp_npc;
      disc_d   = outs_d;
      fl_cnt_d = 2'd0;
    end

    if (ex_branch_flag) begin
      q_cnt_d  = 2'd0;
      disc_d   = outs_d;
      fpc_d    = {ex_branch_address[31:2], 2'b00};
      fl_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc_q       <= RESET_PC;
      outs_q      <= 2'd0;
      disc_q      <= 2'd0;
      q_cnt_q     <= 2'd0;
      fl_cnt_q    <= 2'd0;
      q_pc_q[0]   <= 32'd0;
      q_pc_q[1]   <= 32'd0;
      q_npc_q[0]  <= 32'd0;
      q_npc_q[1]  <= 32'd0;
      q_inst_q[0] <= 32'd0;
      q_inst_q[1] <= 32'd0;
      fl_pc_q[0]  <= 32'd0;
      fl_pc_q[1]  <= 32'd0;
    end else begin
      fpc_q    <= fpc_d;
      outs_q   <= outs_d;
      disc_q   <= disc_d;
      q_cnt_q  <= q_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      q_pc_q   <= q_pc_d;
      q_npc_q  <= q_npc_d;
      q_inst_q <= q_inst_d;
      fl_pc_q  <= fl_pc_d;
    end
  end

  assign if_valid = (q_cnt_q != 2'd0);
  assign if_pc    = q_pc_q[0];
  assign if_npc   = q_npc_q[0];
  assign if_inst  = q_inst_q[0];

endmodule
